// File: rtl/xform_rr_scheduler_if.sv
// Handshake bundle between the per-channel producers, the result consumer and
// xform_rr_scheduler. Requester k occupies bits [k*DATA_W +: DATA_W] of data/mask.
interface xform_rr_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic [NUM_REQ*DATA_W-1:0] req_data_i;
  logic [NUM_REQ*DATA_W-1:0] req_mask_i;
  logic                      res_valid_o;
  logic                      res_ready_i;
  logic [DATA_W-1:0]         res_data_o;
  logic [ID_W-1:0]           res_id_o;

  modport master (
    output req_valid_i, req_data_i, req_mask_i, res_ready_i,
    input  req_ready_o, res_valid_o, res_data_o, res_id_o
  );

  modport slave (
    input  req_valid_i, req_data_i, req_mask_i, res_ready_i,
    output req_ready_o, res_valid_o, res_data_o, res_id_o
  );
endinterface

// File: rtl/xform_rr_scheduler.sv
// Round-robin shared transform res = (data ^ XOR_KEY) & mask with a one-deep
// registered result stage tagged by the winning requester index.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_EMPTY | no result held; any valid requester may be granted
// ST_FULL  | result held; a grant only happens when the consumer drains
module xform_rr_scheduler #(
  parameter int                NUM_REQ = 4,
  parameter int                DATA_W  = 8,
  parameter logic [DATA_W-1:0] XOR_KEY = 'hF0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  xform_rr_scheduler_if.slave   bus
);
  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic {ST_EMPTY, ST_FULL} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic [ID_W-1:0]   res_id_q, res_id_d;

  logic [DATA_W-1:0] data_arr [NUM_REQ];
  logic [DATA_W-1:0] mask_arr [NUM_REQ];
  logic [ID_W-1:0]   grant_idx;
  logic [ID_W-1:0]   cand_idx;
  logic              grant_found;
  logic              can_accept;
  logic              fire;

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      data_arr[k] = bus.req_data_i[k*DATA_W +: DATA_W];
      mask_arr[k] = bus.req_mask_i[k*DATA_W +: DATA_W];
    end
  end

  // First asserted valid at or above rr_ptr, wrapping past NUM_REQ-1.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_idx = ID_W'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (!grant_found && bus.req_valid_i[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_EMPTY;
      rr_ptr_q   <= '0;
      res_data_q <= '0;
      res_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      res_data_q <= res_data_d;
      res_id_q   <= res_id_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    res_data_d      = res_data_q;
    res_id_d        = res_id_q;
    bus.req_ready_o = '0;
    can_accept      = (state_q == ST_EMPTY) || bus.res_ready_i;
    fire            = grant_found && can_accept && !rst_i;

    // A drain and a new grant in the same cycle simply overwrite the slot.
    if (fire) begin
      bus.req_ready_o[grant_idx] = 1'b1;
      state_d    = ST_FULL;
      res_data_d = (data_arr[grant_idx] ^ XOR_KEY) & mask_arr[grant_idx];
      res_id_d   = grant_idx;
      rr_ptr_d   = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end else if ((state_q == ST_FULL) && bus.res_ready_i) begin
      state_d = ST_EMPTY;
    end
  end

  assign bus.res_valid_o = (state_q == ST_FULL);
  assign bus.res_data_o  = res_data_q;
  assign bus.res_id_o    = res_id_q;
endmodule

// File: tb/tb_xform_rr_scheduler.sv
// Bench for xform_rr_scheduler: directed vector table, hand-written corner
// sequences, then protocol-respecting random traffic against a reference model.
module tb_xform_rr_scheduler;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam logic [7:0] KEY = 8'hF0;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  xform_rr_scheduler_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

  xform_rr_scheduler #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .XOR_KEY(KEY)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model of the result slot and pointer
  int         m_full = 0;
  logic [7:0] m_data = '0;
  int         m_id   = 0;
  int         m_ptr  = 0;
  logic [3:0] m_rdy  = '0;

  typedef struct {
    logic       rst;
    logic [3:0] v;
    logic       rr;
    logic [31:0] d;
    logic [31:0] m;
    logic [3:0] e_rdy;
    logic       e_vld;
    logic [7:0] e_dat;
    logic [1:0] e_id;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic addv(input logic rst, input logic [3:0] v, input logic rr,
                      input logic [31:0] d, input logic [31:0] m,
                      input logic [3:0] e_rdy, input logic e_vld,
                      input logic [7:0] e_dat, input logic [1:0] e_id);
    vec_t t;
    t.rst = rst; t.v = v; t.rr = rr; t.d = d; t.m = m;
    t.e_rdy = e_rdy; t.e_vld = e_vld; t.e_dat = e_dat; t.e_id = e_id;
    tbl.push_back(t);
  endtask

  // Model: grant = first valid at/after m_ptr (mod N), only when slot can take it.
  task automatic model_step(input logic rst, input logic [3:0] v, input logic rr,
                            input logic [31:0] d, input logic [31:0] m);
    int g;
    logic [7:0] db, mb;
    g = -1;
    if (!rst && (m_full == 0 || rr)) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (g < 0 && v[(m_ptr + k) % NUM_REQ]) g = (m_ptr + k) % NUM_REQ;
      end
    end
    m_rdy = (g >= 0) ? 4'(1 << g) : 4'b0;
    if (rst) begin
      m_full = 0; m_data = '0; m_id = 0; m_ptr = 0;
    end else if (g >= 0) begin
      db = d[g*8 +: 8];
      mb = m[g*8 +: 8];
      m_data = (db ^ KEY) & mb;
      m_id   = g;
      m_full = 1;
      m_ptr  = (g + 1) % NUM_REQ;
    end else if (m_full != 0 && rr) begin
      m_full = 0;
    end
  endtask

  // One clock: drive, check ready combinationally, clock, check registered outputs.
  task automatic run_cycle(input logic rst, input logic [3:0] v, input logic rr,
                           input logic [31:0] d, input logic [31:0] m,
                           output logic [3:0] rdy_seen, output logic vld_seen,
                           output logic [7:0] dat_seen, output logic [1:0] id_seen);
    rst_i           = rst;
    bus.req_valid_i = v;
    bus.res_ready_i = rr;
    bus.req_data_i  = d;
    bus.req_mask_i  = m;
    #1;
    rdy_seen = bus.req_ready_o;
    model_step(rst, v, rr, d, m);
    chk("model_ready", 32'(rdy_seen), 32'(m_rdy));
    @(posedge clk_i);
    #1;
    vld_seen = bus.res_valid_o;
    dat_seen = bus.res_data_o;
    id_seen  = bus.res_id_o;
    chk("model_valid", 32'(vld_seen), 32'(m_full != 0));
    if (m_full != 0 || rst) begin
      chk("model_data", 32'(dat_seen), 32'(m_data));
      chk("model_id", 32'(id_seen), 32'(m_id));
    end
  endtask

  logic [3:0] rdy;
  logic       vld;
  logic [7:0] dat;
  logic [1:0] id;

  logic [3:0]  pend;
  logic [7:0]  pd [NUM_REQ];
  logic [7:0]  pm [NUM_REQ];
  logic [31:0] rd, rm;
  logic        rrst, rrdy;

  initial begin
    bus.req_valid_i = '0;
    bus.res_ready_i = 1'b0;
    bus.req_data_i  = '0;
    bus.req_mask_i  = '0;
    @(posedge clk_i);
    #1;

    // reset with every requester valid, then first grant goes to 0
    addv(1, 4'hF, 1, 32'h0, 32'h0, 4'b0000, 0, 8'h00, 2'd0);
    addv(1, 4'hF, 1, 32'h0, 32'h0, 4'b0000, 0, 8'h00, 2'd0);
    addv(0, 4'hF, 1, 32'h00000011, 32'h000000FF, 4'b0001, 1, 8'hE1, 2'd0);
    // single request on 2, then masking on 0, then drain
    addv(0, 4'b0100, 1, 32'h003C0000, 32'h00FF0000, 4'b0100, 1, 8'hCC, 2'd2);
    addv(0, 4'b0001, 1, 32'h000000AA, 32'h0000000F, 4'b0001, 1, 8'h0A, 2'd0);
    addv(0, 4'b0000, 1, 32'h0, 32'h0, 4'b0000, 0, 8'h0A, 2'd0);
    // fairness from pointer 0
    addv(1, 4'b0000, 1, 32'h0, 32'h0, 4'b0000, 0, 8'h00, 2'd0);
    addv(0, 4'hF, 1, 32'h33221100, 32'hFFFFFFFF, 4'b0001, 1, 8'hF0, 2'd0);
    addv(0, 4'hF, 1, 32'h33221100, 32'hFFFFFFFF, 4'b0010, 1, 8'hE1, 2'd1);
    addv(0, 4'hF, 1, 32'h33221100, 32'hFFFFFFFF, 4'b0100, 1, 8'hD2, 2'd2);
    addv(0, 4'hF, 1, 32'h33221100, 32'hFFFFFFFF, 4'b1000, 1, 8'hC3, 2'd3);
    addv(0, 4'hF, 1, 32'h33221100, 32'hFFFFFFFF, 4'b0001, 1, 8'hF0, 2'd0);
    addv(0, 4'hF, 1, 32'h33221100, 32'hFFFFFFFF, 4'b0010, 1, 8'hE1, 2'd1);
    // backpressure holding 0x5A, then release grants 3 in the same cycle
    addv(0, 4'b0100, 1, 32'h33AA1100, 32'hFFFFFFFF, 4'b0100, 1, 8'h5A, 2'd2);
    addv(0, 4'hF, 0, 32'h33AA1100, 32'hFFFFFFFF, 4'b0000, 1, 8'h5A, 2'd2);
    addv(0, 4'hF, 0, 32'h33AA1100, 32'hFFFFFFFF, 4'b0000, 1, 8'h5A, 2'd2);
    addv(0, 4'hF, 0, 32'h33AA1100, 32'hFFFFFFFF, 4'b0000, 1, 8'h5A, 2'd2);
    addv(0, 4'hF, 1, 32'h33AA1100, 32'hFFFFFFFF, 4'b1000, 1, 8'hC3, 2'd3);
    // reset while holding discards the result and restarts at requester 0
    addv(0, 4'hF, 0, 32'h33AA1100, 32'hFFFFFFFF, 4'b0000, 1, 8'hC3, 2'd3);
    addv(1, 4'hF, 0, 32'h33AA1100, 32'hFFFFFFFF, 4'b0000, 0, 8'h00, 2'd0);
    addv(0, 4'hF, 0, 32'h33AA1100, 32'hFFFFFFFF, 4'b0001, 1, 8'hF0, 2'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      run_cycle(tbl[i].rst, tbl[i].v, tbl[i].rr, tbl[i].d, tbl[i].m, rdy, vld, dat, id);
      chk($sformatf("vec%0d_ready", i), 32'(rdy), 32'(tbl[i].e_rdy));
      chk($sformatf("vec%0d_valid", i), 32'(vld), 32'(tbl[i].e_vld));
      chk($sformatf("vec%0d_data", i), 32'(dat), 32'(tbl[i].e_dat));
      chk($sformatf("vec%0d_id", i), 32'(id), 32'(tbl[i].e_id));
    end

    // pointer at 1, only requester 0 valid: search must wrap to 0
    run_cycle(0, 4'b0001, 1, 32'h000000C3, 32'h000000FF, rdy, vld, dat, id);
    chk("wrap_ready", 32'(rdy), 32'h1);
    chk("wrap_data", 32'(dat), 32'h33);
    // drain then idle: pointer stays at 1, stale data held
    run_cycle(0, 4'b0000, 1, 32'h0, 32'h0, rdy, vld, dat, id);
    chk("drain_valid", 32'(vld), 32'h0);
    chk("drain_hold_data", 32'(dat), 32'h33);
    run_cycle(0, 4'b0000, 0, 32'h0, 32'h0, rdy, vld, dat, id);
    run_cycle(0, 4'b1010, 0, 32'h00000F00, 32'h0000FF00, rdy, vld, dat, id);
    chk("idle_ptr_ready", 32'(rdy), 32'h2);
    chk("idle_ptr_data", 32'(dat), 32'hFF);
    // zero mask, grant 3 from pointer 2
    run_cycle(0, 4'b1000, 1, 32'hFF000000, 32'h00000000, rdy, vld, dat, id);
    chk("mask0_ready", 32'(rdy), 32'h8);
    chk("mask0_data", 32'(dat), 32'h00);
    chk("mask0_id", 32'(id), 32'h3);

    // random traffic: each requester holds valid/data/mask until granted
    pend = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pd[k] = '0;
      pm[k] = '0;
    end
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!pend[k] && $urandom_range(0, 99) < 45) begin
          pend[k] = 1'b1;
          pd[k]   = 8'($urandom);
          case ($urandom_range(0, 3))
            0: pm[k] = 8'hFF;
            1: pm[k] = 8'h00;
            default: pm[k] = 8'($urandom);
          endcase
        end
      end
      rd = {pd[3], pd[2], pd[1], pd[0]};
      rm = {pm[3], pm[2], pm[1], pm[0]};
      rrst = ($urandom_range(0, 59) == 0);
      rrdy = ($urandom_range(0, 3) != 0);
      run_cycle(rrst, pend, rrdy, rd, rm, rdy, vld, dat, id);
      pend = pend & ~m_rdy;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
